// File: rtl/seq_scan_pkg.sv
// Shared types and defaults for the serial-scan sequencer that feeds seq_detector.
package seq_scan_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FLUSH = 3'd1,
      SHIFT = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } scan_state_t;

   localparam int DEF_W         = 8;
   localparam int DEF_DET_LAT   = 1;
   localparam int DEF_FLUSH_LEN = 2;

   // Wide enough to hold a count of 0..w matches.
   function automatic int cnt_w_of(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/seq_scan_tagpipe.sv
// Delay line that keeps the "this bit is data" tag aligned with the detector's latency.
module seq_scan_tagpipe #(
   parameter int DEPTH = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic tag_in,
   output logic tag_out
);

   logic [DEPTH-1:0] pipe;

   generate
      if (DEPTH == 1) begin : g_single
         always_ff @(posedge clk) begin
            if (!rst_n) pipe <= '0;
            else        pipe <= tag_in;
         end
      end else begin : g_multi
         always_ff @(posedge clk) begin
            if (!rst_n) pipe <= '0;
            else        pipe <= {pipe[DEPTH-2:0], tag_in};
         end
      end
   endgenerate

   assign tag_out = pipe[DEPTH-1];

endmodule

// File: rtl/seq_scan_ctrl.sv
// Word-to-serial sequencer: shifts accepted words MSB-first into the pattern detector
// and returns the number of matches that landed on the word's data bits.
module seq_scan_ctrl
   import seq_scan_pkg::*;
#(
   parameter  int W         = DEF_W,
   parameter  int DET_LAT   = DEF_DET_LAT,
   parameter  int FLUSH_LEN = DEF_FLUSH_LEN,
   localparam int CNT_W     = cnt_w_of(W)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_data,
   input  logic             in_cont,
   output logic             det_a,
   input  logic             det_w,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] out_count
);

   // The phase counter covers the longest state: flush, data, or drain.
   localparam int DRAIN_LEN = DET_LAT + 1;
   localparam int PH_MAX    = (W > FLUSH_LEN) ? ((W > DRAIN_LEN) ? W : DRAIN_LEN)
                                              : ((FLUSH_LEN > DRAIN_LEN) ? FLUSH_LEN : DRAIN_LEN);
   localparam int PH_W      = $clog2(PH_MAX + 1);

   scan_state_t     state, state_n;
   logic [PH_W-1:0] phase, phase_n;
   logic [W-1:0]    shreg;
   logic            tag;
   logic            tag_dly;
   logic            accept;

   // Next-state logic; phase holds the remaining cycles in the current state minus one.
   // det_a is registered from the state, so DRAIN runs one extra cycle to cover that stage.
   always_comb begin
      state_n   = state;
      phase_n   = phase;
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
      accept    = in_valid && (state == IDLE);

      case (state)
         IDLE: begin
            if (accept) begin
               if (!in_cont && (FLUSH_LEN > 0)) begin
                  state_n = FLUSH;
                  phase_n = PH_W'(FLUSH_LEN - 1);
               end else begin
                  state_n = SHIFT;
                  phase_n = PH_W'(W - 1);
               end
            end
         end
         FLUSH: begin
            if (phase == '0) begin
               state_n = SHIFT;
               phase_n = PH_W'(W - 1);
            end else begin
               phase_n = phase - PH_W'(1);
            end
         end
         SHIFT: begin
            if (phase == '0) begin
               state_n = DRAIN;
               phase_n = PH_W'(DRAIN_LEN - 1);
            end else begin
               phase_n = phase - PH_W'(1);
            end
         end
         DRAIN: begin
            if (phase == '0) state_n = DONE;
            else             phase_n = phase - PH_W'(1);
         end
         DONE: begin
            if (out_ready) state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
            phase_n = '0;
         end
      endcase
   end

   // State, shift register, serial output and hit tally.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         phase     <= '0;
         shreg     <= '0;
         det_a     <= 1'b0;
         tag       <= 1'b0;
         out_count <= '0;
      end else begin
         state <= state_n;
         phase <= phase_n;
         if (accept)
            shreg <= in_data;
         else if (state == SHIFT)
            shreg <= {shreg[W-2:0], 1'b0};
         det_a <= (state == SHIFT) ? shreg[W-1] : 1'b0;
         tag   <= (state == SHIFT);
         if (accept)
            out_count <= '0;
         else if (det_w && tag_dly)
            out_count <= out_count + CNT_W'(1);
      end
   end

   seq_scan_tagpipe #(
      .DEPTH (DET_LAT)
   ) u_tagpipe (
      .clk     (clk),
      .rst_n   (rst_n),
      .tag_in  (tag),
      .tag_out (tag_dly)
   );

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Self-checking bench for seq_scan_ctrl driving a behavioural 101 overlapping detector.
module tb_seq_scan_ctrl;

   localparam int W         = 8;
   localparam int DET_LAT   = 1;
   localparam int FLUSH_LEN = 2;
   localparam int CNT_W     = $clog2(W + 1);
   localparam int LAT_FLUSH = FLUSH_LEN + W + DET_LAT + 1;
   localparam int LAT_CONT  = W + DET_LAT + 1;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [W-1:0]     in_data;
   logic             in_cont;
   logic             det_a;
   logic             det_w;
   logic             out_valid;
   logic             out_ready;
   logic [CNT_W-1:0] out_count;

   int tests    = 0;
   int failures = 0;

   logic [1:0] det_hist;
   logic [1:0] model_hist;

   typedef struct {
      logic [W-1:0] data;
      logic         cont;
      int           exp_count;
   } vec_t;

   vec_t vecs[9];

   always #5 clk = ~clk;

   seq_scan_ctrl #(
      .W         (W),
      .DET_LAT   (DET_LAT),
      .FLUSH_LEN (FLUSH_LEN)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_cont   (in_cont),
      .det_a     (det_a),
      .det_w     (det_w),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_count (out_count)
   );

   // Detector stand-in: flags 101 (overlapping) one cycle after the last bit appears.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         det_hist <= 2'b00;
         det_w    <= 1'b0;
      end else begin
         det_hist <= {det_hist[0], det_a};
         det_w    <= ({det_hist, det_a} == 3'b101);
      end
   end

   task automatic checkOutput(input string name, input int got, input int exp);
      tests++;
      if (got != exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // Reference: the detector sees the serial stream; count 101 windows ending on data bits.
   task automatic modelWord(input logic [W-1:0] d, input logic c, output int exp);
      logic [2:0] win;
      exp = 0;
      if (!c)
         for (int i = 0; i < FLUSH_LEN; i++) model_hist = {model_hist[0], 1'b0};
      for (int k = W - 1; k >= 0; k--) begin
         win = {model_hist, d[k]};
         if (win == 3'b101) exp++;
         model_hist = win[1:0];
      end
      for (int i = 0; i < DET_LAT + 1; i++) model_hist = {model_hist[0], 1'b0};
   endtask

   task automatic doReset(input int cycles);
      rst_n = 1'b0;
      repeat (cycles) @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_hist = 2'b00;
   endtask

   // Sends one word, waits for the count, optionally stalls DONE while poking in_valid.
   task automatic applyStimulus(input logic [W-1:0] d, input logic c, input int hold,
                                input logic poke, output int cnt, output int lat,
                                output logic [31:0] trace, output logic stable);
      cnt    = -1;
      lat    = 0;
      trace  = '0;
      stable = 1'b1;
      in_valid = 1'b1;
      in_data  = d;
      in_cont  = c;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = '0;
      while (out_valid !== 1'b1 && lat < 100) begin
         lat++;
         @(posedge clk);
         #1;
         if (lat <= 32) trace[lat-1] = det_a;
      end
      if (out_valid !== 1'b1) begin
         checkOutput("out_valid timeout", 0, 1);
         return;
      end
      cnt = int'(out_count);
      for (int i = 0; i < hold; i++) begin
         in_valid = poke;
         in_data  = ~d;
         in_cont  = 1'b1;
         @(posedge clk);
         #1;
         if (out_valid !== 1'b1 || int'(out_count) != cnt || in_ready !== 1'b0) stable = 1'b0;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   initial begin
      int          cnt, lat, exp;
      logic [31:0] trace;
      logic        stable;
      logic [W-1:0] rd;
      logic        rc;

      vecs[0] = '{8'h00, 1'b0, 0};
      vecs[1] = '{8'hFF, 1'b0, 0};
      vecs[2] = '{8'h02, 1'b0, 0};
      vecs[3] = '{8'h80, 1'b1, 0};
      vecs[4] = '{8'h05, 1'b0, 1};
      vecs[5] = '{8'h55, 1'b0, 3};
      vecs[6] = '{8'hAA, 1'b1, 3};
      vecs[7] = '{8'h2D, 1'b0, 2};
      vecs[8] = '{8'hB5, 1'b1, 3};

      in_valid   = 1'b0;
      in_data    = '0;
      in_cont    = 1'b0;
      out_ready  = 1'b0;
      model_hist = 2'b00;

      doReset(3);
      checkOutput("reset in_ready", int'(in_ready), 1);
      checkOutput("reset out_valid", int'(out_valid), 0);
      checkOutput("reset out_count", int'(out_count), 0);
      checkOutput("reset det_a", int'(det_a), 0);

      // Flushed word: serial trace, count and latency.
      modelWord(8'hA5, 1'b0, exp);
      applyStimulus(8'hA5, 1'b0, 0, 1'b0, cnt, lat, trace, stable);
      checkOutput("A5 det_a trace", int'(trace[9:0]), int'(10'b1010010100));
      checkOutput("A5 count", cnt, exp);
      checkOutput("A5 count const", cnt, 2);
      checkOutput("A5 latency", lat, LAT_FLUSH);
      checkOutput("A5 in_ready after", int'(in_ready), 1);

      for (int i = 0; i < 9; i++) begin
         modelWord(vecs[i].data, vecs[i].cont, exp);
         applyStimulus(vecs[i].data, vecs[i].cont, i % 3, 1'b0, cnt, lat, trace, stable);
         checkOutput($sformatf("vec%0d count", i), cnt, vecs[i].exp_count);
         checkOutput($sformatf("vec%0d latency", i), lat,
                     vecs[i].cont ? LAT_CONT : LAT_FLUSH);
         checkOutput($sformatf("vec%0d in_ready", i), int'(in_ready), 1);
      end

      // Stall in DONE while a new word is offered; it must be ignored.
      modelWord(8'h2D, 1'b0, exp);
      applyStimulus(8'h2D, 1'b0, 5, 1'b1, cnt, lat, trace, stable);
      checkOutput("stall stable", int'(stable), 1);
      checkOutput("stall count", cnt, exp);
      checkOutput("stall in_ready after", int'(in_ready), 1);
      modelWord(8'h05, 1'b1, exp);
      applyStimulus(8'h05, 1'b1, 0, 1'b0, cnt, lat, trace, stable);
      checkOutput("post-stall count", cnt, exp);

      // Reset during the shift of bit 4 aborts the word.
      in_valid = 1'b1;
      in_data  = 8'hF0;
      in_cont  = 1'b0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("midreset in_ready", int'(in_ready), 1);
      checkOutput("midreset out_valid", int'(out_valid), 0);
      checkOutput("midreset out_count", int'(out_count), 0);
      checkOutput("midreset det_a", int'(det_a), 0);
      rst_n = 1'b1;
      model_hist = 2'b00;
      modelWord(8'h05, 1'b0, exp);
      applyStimulus(8'h05, 1'b0, 0, 1'b0, cnt, lat, trace, stable);
      checkOutput("after reset 05 count", cnt, 1);

      // Random words against the reference stream model.
      for (int i = 0; i < 40; i++) begin
         rd = W'($urandom);
         rc = 1'($urandom_range(0, 1));
         modelWord(rd, rc, exp);
         applyStimulus(rd, rc, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                       cnt, lat, trace, stable);
         checkOutput($sformatf("rand%0d count d=%02h c=%0d", i, rd, rc), cnt, exp);
         checkOutput($sformatf("rand%0d latency", i), lat, rc ? LAT_CONT : LAT_FLUSH);
         checkOutput($sformatf("rand%0d stable", i), int'(stable), 1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
